fwd_dispatcher: RTL

FWD_DISPATCHER -- requirements
Module: fwd_dispatcher

---
 rtl/fwd_dispatcher.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/fwd_dispatcher.sv
// -----------------------------------------------------------------------------
// fwd_dispatcher
//
// Queues incoming frame descriptors and, one at a time from the queue head,
// resolves the egress ports: group destinations are flooded directly, unicast
// destinations are looked up in an external table (with a bounded wait). The
// resulting write-request mask is presented to the egress side until it is
// accepted. Frames that would only go back out of their ingress port are
// dropped.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start_ptr_i         frame start pointer in frame memory
//   dest_addr_i         destination MAC address
//   src_port_i          ingress port of the frame
//   input_valid_i       descriptor valid
//   input_ready_o       descriptor queue not full
//   lookup_req_o        one-cycle lookup request strobe
//   lookup_addr_o       address being looked up
//   lookup_valid_i      lookup response valid
//   lookup_hit_i        response is a table hit
//   lookup_port_i       egress port on a hit
//   write_reqs_o        per-port write request mask
//   start_ptrs_o        per-port start pointer (0 on ports not requested)
//   copies_o            number of set bits in write_reqs_o
//   dispatch_ready_i    egress side accepts the current dispatch
//   flood_count_o       saturating count of flooded frames
//   drop_count_o        saturating count of filtered frames
// -----------------------------------------------------------------------------
module fwd_dispatcher #(
    parameter int NUM_PORTS      = 4,
    parameter int ADDR_W         = 12,
    parameter int QUEUE_DEPTH    = 4,
    parameter int LOOKUP_TIMEOUT = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ADDR_W-1:0]                   start_ptr_i,
    input  logic [47:0]                         dest_addr_i,
    input  logic [$clog2(NUM_PORTS)-1:0]        src_port_i,
    input  logic                                input_valid_i,
    output logic                                input_ready_o,
    output logic                                lookup_req_o,
    output logic [47:0]                         lookup_addr_o,
    input  logic                                lookup_valid_i,
    input  logic                                lookup_hit_i,
    input  logic [$clog2(NUM_PORTS)-1:0]        lookup_port_i,
    output logic [NUM_PORTS-1:0]                write_reqs_o,
    output logic [NUM_PORTS-1:0][ADDR_W-1:0]    start_ptrs_o,
    output logic [$clog2(NUM_PORTS):0]          copies_o,
    input  logic                                dispatch_ready_i,
    output logic [15:0]                         flood_count_o,
    output logic [15:0]                         drop_count_o
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int QW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(LOOKUP_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, DISPATCH} state_t;

    // ---------------- descriptor queue ----------------
    logic [ADDR_W-1:0] ptr_mem  [QUEUE_DEPTH];
    logic [47:0]       dest_mem [QUEUE_DEPTH];
    logic [PW-1:0]     src_mem  [QUEUE_DEPTH];
    logic [QW-1:0]     wr_idx, rd_idx;
    logic [QW:0]       count, count_next;
    logic              full, empty, push, pop;

    logic [ADDR_W-1:0] head_ptr;
    logic [47:0]       head_dest;
    logic [PW-1:0]     head_src;

    assign push          = input_valid_i && !full;
    assign empty         = (count == '0);
    assign input_ready_o = !full;
    assign head_ptr      = ptr_mem[rd_idx];
    assign head_dest     = dest_mem[rd_idx];
    assign head_src      = src_mem[rd_idx];

    // NOTE: the storage array is deliberately not reset; count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            ptr_mem[wr_idx]  <= start_ptr_i;
            dest_mem[wr_idx] <= dest_addr_i;
            src_mem[wr_idx]  <= src_port_i;
        end
    end

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) wr_idx <= wr_idx + 1'b1;
            if (pop)  rd_idx <= rd_idx + 1'b1;
            count <= count_next;
            full  <= (count_next == (QW+1)'(QUEUE_DEPTH));
        end
    end

    // ---------------- forwarding FSM ----------------
    state_t                          state, state_next;
    logic [CW-1:0]                   cnt, cnt_next;
    logic                            req_next, load, flood_evt, drop_evt;
    logic [47:0]                     addr_next;
    logic [NUM_PORTS-1:0]            mask_sel, flood_mask, hit_mask;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] ptrs_sel;

    assign flood_mask = ~(NUM_PORTS'(1) << head_src);
    assign hit_mask   = NUM_PORTS'(1) << lookup_port_i;

    function automatic logic [PW:0] popcount(input logic [NUM_PORTS-1:0] m);
        logic [PW:0] c;
        c = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            c = c + (PW+1)'(m[i]);
        return c;
    endfunction

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_next = state;
        pop        = 1'b0;
        req_next   = 1'b0;
        addr_next  = lookup_addr_o;
        cnt_next   = cnt;
        load       = 1'b0;
        mask_sel   = '0;
        flood_evt  = 1'b0;
        drop_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (head_dest[40]) begin
                        load       = 1'b1;
                        mask_sel   = flood_mask;
                        flood_evt  = 1'b1;
                        state_next = DISPATCH;
                    end else begin
                        req_next   = 1'b1;
                        addr_next  = head_dest;
                        cnt_next   = CW'(1);
                        state_next = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                cnt_next = cnt + 1'b1;
                // A response takes priority, even in the timeout cycle.
                if (lookup_valid_i) begin
                    if (!lookup_hit_i) begin
                        load       = 1'b1;
                        mask_sel   = flood_mask;
                        flood_evt  = 1'b1;
                        state_next = DISPATCH;
                    end else if (lookup_port_i == head_src) begin
                        pop        = 1'b1;
                        drop_evt   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        load       = 1'b1;
                        mask_sel   = hit_mask;
                        state_next = DISPATCH;
                    end
                end else if (cnt == CW'(LOOKUP_TIMEOUT)) begin
                    load       = 1'b1;
                    mask_sel   = flood_mask;
                    flood_evt  = 1'b1;
                    state_next = DISPATCH;
                end
            end
            DISPATCH: begin
                if (dispatch_ready_i) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++)
            ptrs_sel[i] = mask_sel[i] ? head_ptr : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            lookup_req_o  <= 1'b0;
            lookup_addr_o <= '0;
            write_reqs_o  <= '0;
            start_ptrs_o  <= '0;
            copies_o      <= '0;
            flood_count_o <= '0;
            drop_count_o  <= '0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            lookup_req_o  <= req_next;
            lookup_addr_o <= addr_next;
            if (load) begin
                write_reqs_o <= mask_sel;
                start_ptrs_o <= ptrs_sel;
                copies_o     <= popcount(mask_sel);
            end else if (pop) begin
                write_reqs_o <= '0;
                start_ptrs_o <= '0;
                copies_o     <= '0;
            end
            if (flood_evt && flood_count_o != 16'hFFFF)
                flood_count_o <= flood_count_o + 16'd1;
            if (drop_evt && drop_count_o != 16'hFFFF)
                drop_count_o <= drop_count_o + 16'd1;
        end
    end

endmodule
